// File: rtl/axi_rd_stream_pkg.sv
// Shared types and AXI constants for the AXI read-to-stream engine.
package axi_rd_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_ADDR  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_MOD  = 4'h2;
    localparam logic [2:0] AXI_PROT_NS    = 3'h2;
    localparam logic [1:0] RESP_OKAY      = 2'b00;

    // AXI arsize encoding for a beat of data_w bits
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/iob_fifo_sync.sv
// Synchronous first-word-fall-through FIFO used as the beat buffer.
module iob_fifo_sync #(
    parameter int W      = 32,
    parameter int ADDR_W = 5
) (
    input  logic         clk_i,
    input  logic         arst_n_i,
    input  logic         cke_i,
    input  logic         w_en_i,
    input  logic [W-1:0] w_data_i,
    input  logic         r_en_i,
    output logic [W-1:0] r_data_o,
    output logic         empty_o,
    output logic         full_o
);

    logic [W-1:0]    mem [2**ADDR_W];
    logic [ADDR_W:0] wptr, rptr;

    // Pointer update; extra MSB distinguishes full from empty
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wptr <= '0;
            rptr <= '0;
        end else if (cke_i) begin
            if (w_en_i && !full_o)  wptr <= wptr + (ADDR_W+1)'(1);
            if (r_en_i && !empty_o) rptr <= rptr + (ADDR_W+1)'(1);
        end
    end

    // Storage write; contents need no reset
    always_ff @(posedge clk_i) begin
        if (cke_i && w_en_i && !full_o) mem[wptr[ADDR_W-1:0]] <= w_data_i;
    end

    assign r_data_o = mem[rptr[ADDR_W-1:0]];
    assign empty_o  = (wptr == rptr);
    assign full_o   = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                      (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

endmodule

// File: rtl/axi_rd_stream.sv
// Reads a linear block over AXI4 and streams the beats out in order.
// Bursts are sized so the beat buffer can always absorb them.
module axi_rd_stream
    import axi_rd_stream_pkg::*;
#(
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1,
    parameter int BURST_W    = 4,
    parameter int BUFFER_W   = 5,
    parameter int OUTST_W    = 2
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  cke_i,
    input  logic [AXI_ADDR_W-1:0] cfg_addr_i,
    input  logic [AXI_ADDR_W-1:0] cfg_len_i,
    input  logic                  cfg_valid_i,
    output logic                  cfg_ready_o,
    output logic [AXI_DATA_W-1:0] axis_data_o,
    output logic                  axis_last_o,
    output logic                  axis_valid_o,
    input  logic                  axis_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [AXI_ID_W-1:0]   axi_arid_o,
    output logic [AXI_ADDR_W-1:0] axi_araddr_o,
    output logic [AXI_LEN_W-1:0]  axi_arlen_o,
    output logic [2:0]            axi_arsize_o,
    output logic [1:0]            axi_arburst_o,
    output logic                  axi_arlock_o,
    output logic [3:0]            axi_arcache_o,
    output logic [2:0]            axi_arprot_o,
    output logic [3:0]            axi_arqos_o,
    output logic                  axi_arvalid_o,
    input  logic                  axi_arready_i,
    input  logic [AXI_DATA_W-1:0] axi_rdata_i,
    input  logic [1:0]            axi_rresp_i,
    input  logic                  axi_rlast_i,
    input  logic                  axi_rvalid_i,
    input  logic [AXI_ID_W-1:0]   axi_rid_i,
    output logic                  axi_rready_o
);

    localparam int BYTES_W = $clog2(AXI_DATA_W / 8);
    localparam int CRED_W  = BUFFER_W + 1;
    localparam int MW      = (AXI_ADDR_W > 13) ? AXI_ADDR_W : 13;
    localparam logic [OUTST_W-1:0] OUTST_MAX = '1;

    state_t                state;
    logic [AXI_ADDR_W-1:0] addr_q, rem_q, len_q, pop_cnt;
    logic [AXI_LEN_W-1:0]  arlen_q;
    logic [BURST_W:0]      burst_q;
    logic [CRED_W-1:0]     credits;
    logic [OUTST_W-1:0]    outst;
    logic                  arvalid_q, busy_q, done_q, error_q;
    logic [MW-1:0]         bnd_beats, burst_c;
    logic                  calc_go, r_hs, r_done, ar_hs, ax_hs, cfg_hs, fifo_empty, fifo_full;
    logic                  unused_ok;

    assign r_hs   = axi_rvalid_i && axi_rready_o;
    assign r_done = r_hs && axi_rlast_i;
    assign ar_hs  = axi_arvalid_o && axi_arready_i;
    assign ax_hs  = axis_valid_o && axis_ready_i;
    assign cfg_hs = cfg_valid_i && cfg_ready_o;

    // Beats left before the next 4 KB page; only meaningful with wide addresses
    generate
        if (AXI_ADDR_W >= 13) begin : g_bnd
            assign bnd_beats = MW'((13'h1000 - {1'b0, addr_q[11:0]}) >> BYTES_W);
        end else begin : g_nobnd
            assign bnd_beats = '1;
        end
    endgenerate

    // Burst size: remaining, capped by max burst and page boundary
    always_comb begin
        burst_c = MW'(rem_q);
        if (burst_c > MW'(2**BURST_W)) burst_c = MW'(2**BURST_W);
        if (burst_c > bnd_beats)       burst_c = bnd_beats;
    end

    // Wait for room for the whole burst rather than issuing fragments
    assign calc_go = (burst_c != '0) && (burst_c <= MW'(credits)) && (outst != OUTST_MAX);

    // Main control FSM with registered AR and status outputs
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            len_q     <= '0;
            arlen_q   <= '0;
            burst_q   <= '0;
            arvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (cke_i) begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: if (cfg_valid_i) begin
                    addr_q <= cfg_addr_i;
                    rem_q  <= cfg_len_i;
                    len_q  <= cfg_len_i;
                    if (cfg_len_i == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b1;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: if (calc_go) begin
                    arlen_q   <= AXI_LEN_W'(burst_c - MW'(1));
                    burst_q   <= (BURST_W+1)'(burst_c);
                    rem_q     <= rem_q - AXI_ADDR_W'(burst_c);
                    arvalid_q <= 1'b1;
                    state     <= ST_ADDR;
                end
                ST_ADDR: if (axi_arready_i) begin
                    arvalid_q <= 1'b0;
                    addr_q    <= addr_q + (AXI_ADDR_W'(burst_q) << BYTES_W);
                    state     <= (rem_q != '0) ? ST_CALC : ST_DRAIN;
                end
                ST_DRAIN: if (outst == '0 && pop_cnt == len_q) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Buffer credits: taken when a burst is committed, returned per popped beat
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) credits <= CRED_W'(2**BUFFER_W);
        else if (cke_i)
            credits <= credits
                     - ((state == ST_CALC && calc_go) ? CRED_W'(burst_c) : '0)
                     + CRED_W'(ax_hs);
    end

    // Outstanding bursts: issued on AR handshake, retired on rlast
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)  outst <= '0;
        else if (cke_i) outst <= outst + OUTST_W'(ar_hs) - OUTST_W'(r_done);
    end

    // Popped-beat counter locates the final stream beat
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)   pop_cnt <= '0;
        else if (cke_i) begin
            if (cfg_hs)     pop_cnt <= '0;
            else if (ax_hs) pop_cnt <= pop_cnt + AXI_ADDR_W'(1);
        end
    end

    // Sticky error from any non-OKAY read response, cleared by a new job
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)   error_q <= 1'b0;
        else if (cke_i) begin
            if (cfg_hs)                                 error_q <= 1'b0;
            else if (r_hs && axi_rresp_i != RESP_OKAY) error_q <= 1'b1;
        end
    end

    iob_fifo_sync #(
        .W      (AXI_DATA_W),
        .ADDR_W (BUFFER_W)
    ) u_fifo (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .cke_i    (cke_i),
        .w_en_i   (r_hs),
        .w_data_i (axi_rdata_i),
        .r_en_i   (axis_ready_i),
        .r_data_o (axis_data_o),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full)
    );

    assign cfg_ready_o   = (state == ST_IDLE);
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = error_q;
    assign axis_valid_o  = !fifo_empty;
    assign axis_last_o   = axis_valid_o && (pop_cnt == len_q - AXI_ADDR_W'(1));
    assign axi_rready_o  = busy_q;
    assign axi_arvalid_o = arvalid_q;
    assign axi_araddr_o  = addr_q;
    assign axi_arlen_o   = arlen_q;
    assign axi_arid_o    = '0;
    assign axi_arsize_o  = axi_size(AXI_DATA_W);
    assign axi_arburst_o = AXI_BURST_INCR;
    assign axi_arlock_o  = 1'b0;
    assign axi_arcache_o = AXI_CACHE_MOD;
    assign axi_arprot_o  = AXI_PROT_NS;
    assign axi_arqos_o   = '0;

    // Read id is ignored (single id) and credits keep the FIFO from filling past capacity
    assign unused_ok = ^{axi_rid_i, fifo_full};

endmodule

// File: tb/tb_axi_rd_stream.sv
// Directed bench for axi_rd_stream: job table plus reset/latency sequences.
module tb_axi_rd_stream;

    logic        clk = 1'b0, arst_n = 1'b0, cke = 1'b1;
    logic [31:0] cfg_addr = '0, cfg_len = '0;
    logic        cfg_valid = 1'b0, cfg_ready;
    logic [31:0] axis_data;
    logic        axis_last, axis_valid, axis_ready = 1'b1;
    logic        busy, done, error;
    logic [0:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst;
    logic        arlock, arvalid, arready = 1'b1;
    logic [3:0]  arcache, arqos;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0, rvalid = 1'b0, rready;
    logic [0:0]  rid = '0;

    always #5 clk = ~clk;

    axi_rd_stream dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .cfg_addr_i(cfg_addr), .cfg_len_i(cfg_len), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready),
        .axis_data_o(axis_data), .axis_last_o(axis_last), .axis_valid_o(axis_valid), .axis_ready_i(axis_ready),
        .busy_o(busy), .done_o(done), .error_o(error),
        .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen), .axi_arsize_o(arsize),
        .axi_arburst_o(arburst), .axi_arlock_o(arlock), .axi_arcache_o(arcache), .axi_arprot_o(arprot),
        .axi_arqos_o(arqos), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
        .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast), .axi_rvalid_i(rvalid),
        .axi_rid_i(rid), .axi_rready_o(rready)
    );

    typedef struct {
        logic [31:0] addr;
        int          len, stall, err_beat, cke_hold;
        bit          ar_slow;
        int          nar, arlen0;      // nar < 0: burst count not checked
        logic [31:0] araddr1;
        int          arlen_last;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } burst_t;

    vec_t   vecs[6];
    burst_t sl_q[$];
    int     ar_len_log[$];
    logic [31:0] ar_addr_log[$];

    int checks = 0, failures = 0;
    int cyc = 0, acc_cyc, arv_cyc, rfirst_cyc, axv_cyc;
    int n_beats, data_err, n_last, last_idx, done_cnt, rdy_drop, ar_beats, max_ahead;
    int sl_beat = 0, r_idx = 0, err_beat = -1;
    logic [31:0] exp_base;
    bit  ar_slow = 1'b0, r_hs_f = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: handshakes seen here complete at the following rising edge
    always @(negedge clk) begin
        cyc++;
        if (arst_n && cke) begin
            if (cfg_valid && cfg_ready) acc_cyc = cyc;
            if (arvalid && arv_cyc < 0) arv_cyc = cyc;
            if (axis_valid && axv_cyc < 0) axv_cyc = cyc;
            if (arvalid && arready) begin
                ar_addr_log.push_back(araddr);
                ar_len_log.push_back(int'(arlen));
                sl_q.push_back('{araddr, int'(arlen)});
                ar_beats += int'(arlen) + 1;
            end
            r_hs_f = rvalid && rready;
            if (r_hs_f && rfirst_cyc < 0) rfirst_cyc = cyc;
            if (axis_valid && axis_ready) begin
                if (axis_data !== exp_base + 32'(4 * n_beats)) data_err++;
                if (axis_last) begin n_last++; last_idx = n_beats; end
                n_beats++;
            end
            if (busy && !rready) rdy_drop++;
            if (ar_beats - n_beats > max_ahead) max_ahead = ar_beats - n_beats;
            if (done) done_cnt++;
        end else begin
            r_hs_f = 1'b0;
        end
    end

    // AXI slave model: data word = its byte address
    always @(posedge clk) begin
        #1;
        if (!arst_n) begin
            sl_q.delete();
            sl_beat = 0;
            rvalid = 1'b0;
            rlast = 1'b0;
            rresp = 2'b00;
        end else begin
            arready = ar_slow ? ~arready : 1'b1;
            if (r_hs_f && sl_q.size() > 0) begin
                r_idx++;
                if (sl_beat == sl_q[0].len) begin
                    void'(sl_q.pop_front());
                    sl_beat = 0;
                end else sl_beat++;
            end
            if (sl_q.size() > 0) begin
                rvalid = 1'b1;
                rdata = sl_q[0].addr + 32'(4 * sl_beat);
                rlast = (sl_beat == sl_q[0].len);
                rresp = (r_idx == err_beat) ? 2'b10 : 2'b00;
            end else begin
                rvalid = 1'b0;
                rlast = 1'b0;
                rresp = 2'b00;
            end
        end
    end

    task automatic clear_mon(input vec_t v);
        n_beats = 0; data_err = 0; n_last = 0; last_idx = -1; done_cnt = 0;
        rdy_drop = 0; ar_beats = 0; max_ahead = 0; r_idx = 0;
        acc_cyc = -1; arv_cyc = -1; rfirst_cyc = -1; axv_cyc = -1;
        ar_len_log.delete(); ar_addr_log.delete();
        exp_base = v.addr; err_beat = v.err_beat; ar_slow = v.ar_slow;
    endtask

    task automatic start_job(input vec_t v, input string tag);
        int to;
        clear_mon(v);
        axis_ready = (v.stall == 0);
        @(posedge clk); #1;
        cfg_addr = v.addr; cfg_len = 32'(v.len); cfg_valid = 1'b1;
        to = 0;
        do begin @(negedge clk); to++; end while (!cfg_ready && to < 200);
        chk({tag, "_accept_to"}, to < 200, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_err_clr"}, error, 0);
    endtask

    task automatic run_job(input vec_t v, input string tag);
        int to;
        start_job(v, tag);
        if (v.stall > 0) begin
            repeat (v.stall) @(posedge clk);
            #1 axis_ready = 1'b1;
        end
        if (v.cke_hold > 0) begin
            repeat (3) @(posedge clk);
            #1 cke = 1'b0;
            repeat (v.cke_hold) @(posedge clk);
            #1 cke = 1'b1;
        end
        to = 0;
        while (done_cnt == 0 && to < 5000) begin @(negedge clk); to++; end
        chk({tag, "_done_to"}, to < 5000, 1);
        repeat (5) @(negedge clk);
        if (v.nar >= 0) chk({tag, "_nar"}, ar_len_log.size(), v.nar);
        if (v.nar > 0 && ar_len_log.size() > 0) begin
            chk({tag, "_araddr0"}, ar_addr_log[0], v.addr);
            chk({tag, "_arlen0"}, ar_len_log[0], v.arlen0);
            chk({tag, "_arlen_last"}, ar_len_log[ar_len_log.size()-1], v.arlen_last);
            chk({tag, "_ar_lat"}, arv_cyc - acc_cyc, 2);
            chk({tag, "_axis_lat"}, axv_cyc - rfirst_cyc, 1);
        end
        if (v.nar > 1 && ar_addr_log.size() > 1) chk({tag, "_araddr1"}, ar_addr_log[1], v.araddr1);
        chk({tag, "_beats"}, n_beats, v.len);
        chk({tag, "_data"}, data_err, 0);
        chk({tag, "_nlast"}, n_last, (v.len > 0) ? 1 : 0);
        if (v.len > 0) chk({tag, "_last_idx"}, last_idx, v.len - 1);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_error"}, error, v.exp_err);
        chk({tag, "_idle"}, {cfg_ready, busy}, 2'b10);
        chk({tag, "_rready_drop"}, rdy_drop, 0);
        chk({tag, "_ahead_le32"}, max_ahead <= 32, 1);
    endtask

    initial begin
        int to;
        vec_t rv;
        //          addr          len stall err cke slow nar arlen0 araddr1     last err
        vecs[0] = '{32'h0000_0100, 40,   0, -1,  0, 0,   3, 15, 32'h0000_0140,  7, 0};
        vecs[1] = '{32'h0000_0FF8,  8,   0, -1,  0, 0,   2,  1, 32'h0000_1000,  5, 0};
        vecs[2] = '{32'h0000_2000, 64, 100, -1,  0, 0,   4, 15, 32'h0000_2040, 15, 0};
        vecs[3] = '{32'h0000_0300, 10,   0,  3,  0, 0,   1,  9, 32'h0000_0000,  9, 1};
        vecs[4] = '{32'h0000_0400,  0,   0, -1,  0, 0,   0,  0, 32'h0000_0000,  0, 0};
        vecs[5] = '{32'h0000_0FC0, 20,   0, -1,  6, 1,   2, 15, 32'h0000_1000,  3, 0};

        // Reset state and fixed AR fields
        #12;
        chk("rst_outputs", {cfg_ready, arvalid, rready, axis_valid, axis_last, busy, done, error}, 8'b1000_0000);
        chk("ar_consts", {arid, arsize, arburst, arlock, arcache, arprot, arqos},
            {1'b0, 3'd2, 2'd1, 1'b0, 4'd2, 3'd2, 4'd0});
        @(posedge clk); #2 arst_n = 1'b1;

        foreach (vecs[i]) run_job(vecs[i], $sformatf("v%0d", i));

        // Reset in the middle of a job, then a fresh job
        rv = '{32'h0000_0500, 40, 0, -1, 0, 0, 3, 15, 32'h0000_0540, 7, 0};
        start_job(rv, "mid");
        to = 0;
        while (n_beats < 5 && to < 500) begin @(negedge clk); to++; end
        chk("mid_progress_to", to < 500, 1);
        @(posedge clk); #2 arst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", {cfg_ready, arvalid, rready, axis_valid, axis_last, busy, done, error}, 8'b1000_0000);
        repeat (3) @(posedge clk);
        #2 arst_n = 1'b1;
        run_job(rv, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
